// File: rtl/pwm_pkg.sv
// Shared sizing helpers and duty types for the multichannel PWM block.
package pwm_pkg;

  localparam int PWM_WORD_LENGTH_DEFAULT = 8;

  // Duty counts span 0..WORD_LENGTH inclusive, hence the +1.
  function automatic int duty_width(input int word_length);
    return $clog2(word_length + 1);
  endfunction

  localparam int DUTY_W = duty_width(PWM_WORD_LENGTH_DEFAULT);

  typedef logic [DUTY_W-1:0] duty_t;

endpackage

// File: rtl/onehot_duty_decoder.sv
// Converts a one-hot duty word into a high-time count; flags multi-hot words.
module onehot_duty_decoder
  import pwm_pkg::*;
#(
  parameter int WORD_LENGTH = 8,
  parameter int DW          = duty_width(WORD_LENGTH)
) (
  input  logic [WORD_LENGTH-1:0] i_duty,
  output logic [DW-1:0]          o_duty,
  output logic                   o_multi
);

  logic [DW-1:0] w_ones;
  logic [DW-1:0] w_pos;

  always_comb begin
    w_ones = '0;
    w_pos  = '0;
    for (int k = 0; k < WORD_LENGTH; k++) begin
      if (i_duty[k]) begin
        w_ones = w_ones + DW'(1);
        w_pos  = DW'(k + 1);
      end
    end
  end

  // Only a single set bit yields a nonzero count; zero and multi-hot both give 0.
  assign o_multi = (w_ones > DW'(1));
  assign o_duty  = (w_ones == DW'(1)) ? w_pos : '0;

endmodule

// File: rtl/pwm_multichannel.sv
// Multichannel PWM: shared prescaler and step counter, per-channel shadow/active duty.
module pwm_multichannel
  import pwm_pkg::*;
#(
  parameter int WORD_LENGTH = 8,
  parameter int CHANNELS    = 4,
  parameter int PRESCALE    = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [CHANNELS-1:0]    load_i,
  input  logic [WORD_LENGTH-1:0] duty_i,
  input  logic                   enable_i,
  output logic [CHANNELS-1:0]    pwm_o,
  output logic                   period_start_o,
  output logic [CHANNELS-1:0]    invalid_o
);

  localparam int DW = duty_width(WORD_LENGTH);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [DW-1:0] CNT_LAST   = DW'(WORD_LENGTH - 1);

  logic [DW-1:0] w_duty;
  logic          w_multi;

  onehot_duty_decoder #(
    .WORD_LENGTH (WORD_LENGTH),
    .DW          (DW)
  ) u_decoder (
    .i_duty  (duty_i),
    .o_duty  (w_duty),
    .o_multi (w_multi)
  );

  logic [PW-1:0] r_presc;
  logic [DW-1:0] r_cnt;
  logic          r_period_start;
  logic          w_tick;
  logic          w_wrap;

  assign w_tick = enable_i && (r_presc == PRESC_LAST);
  assign w_wrap = w_tick && (r_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc        <= '0;
      r_cnt          <= '0;
      r_period_start <= 1'b0;
    end else begin
      // The pulse marks the first enabled clock of step 0, where pwm_o picks up cnt=0.
      r_period_start <= enable_i && (r_cnt == '0) && (r_presc == '0);
      if (enable_i) begin
        r_presc <= w_tick ? '0 : r_presc + PW'(1);
        if (w_tick) begin
          r_cnt <= w_wrap ? '0 : r_cnt + DW'(1);
        end
      end
    end
  end

  assign period_start_o = r_period_start;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [DW-1:0] r_shadow;
    logic [DW-1:0] r_active;
    logic          r_pwm;
    logic          r_invalid;

    always_ff @(posedge clk) begin
      if (reset) begin
        r_shadow  <= '0;
        r_active  <= '0;
        r_pwm     <= 1'b0;
        r_invalid <= 1'b0;
      end else begin
        if (load_i[gi]) begin
          r_shadow <= w_duty;
          if (w_multi) begin
            r_invalid <= 1'b1;
          end
        end
        // A load landing on the wrap tick goes straight into the new period.
        if (w_wrap) begin
          r_active <= load_i[gi] ? w_duty : r_shadow;
        end
        if (enable_i) begin
          r_pwm <= (r_cnt < r_active);
        end
      end
    end

    assign pwm_o[gi]     = r_pwm;
    assign invalid_o[gi] = r_invalid;
  end

endmodule

// File: tb/tb_pwm_multichannel.sv
// Bench for pwm_multichannel: PRESCALE=1 and PRESCALE=3 instances against an arithmetic model.
module tb_pwm_multichannel;

  localparam int WL = 8;
  localparam int CH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst  [2];
  logic [CH-1:0] load [2];
  logic [WL-1:0] duty [2];
  logic          en   [2];
  logic [CH-1:0] pwm  [2];
  logic          ps   [2];
  logic [CH-1:0] inv  [2];

  int checks   = 0;
  int failures = 0;

  pwm_multichannel #(.WORD_LENGTH(WL), .CHANNELS(CH), .PRESCALE(1)) dut0 (
    .clk(clk), .reset(rst[0]), .load_i(load[0]), .duty_i(duty[0]), .enable_i(en[0]),
    .pwm_o(pwm[0]), .period_start_o(ps[0]), .invalid_o(inv[0])
  );

  pwm_multichannel #(.WORD_LENGTH(WL), .CHANNELS(CH), .PRESCALE(3)) dut1 (
    .clk(clk), .reset(rst[1]), .load_i(load[1]), .duty_i(duty[1]), .enable_i(en[1]),
    .pwm_o(pwm[1]), .period_start_o(ps[1]), .invalid_o(inv[1])
  );

  // Reference model: position in the PWM cycle is derived from a count of enabled clocks.
  int            m_e   [2];
  int            m_sh  [2][CH];
  int            m_act [2][CH];
  logic [CH-1:0] m_pwm [2];
  logic          m_ps  [2];
  logic [CH-1:0] m_inv [2];

  function automatic int dec(input logic [WL-1:0] w);
    logic [WL-1:0] one;
    one = 1;
    for (int k = 0; k < WL; k++) begin
      if (w == (one << k)) return k + 1;
    end
    return 0;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int p;
      int cnt;
      int d;
      p   = (i == 0) ? 1 : 3;
      d   = dec(duty[i]);
      cnt = (m_e[i] / p) % WL;
      if (rst[i]) begin
        m_e[i]   <= 0;
        m_pwm[i] <= '0;
        m_ps[i]  <= 1'b0;
        m_inv[i] <= '0;
        for (int c = 0; c < CH; c++) begin
          m_sh[i][c]  <= 0;
          m_act[i][c] <= 0;
        end
      end else begin
        for (int c = 0; c < CH; c++) begin
          if (load[i][c]) begin
            m_sh[i][c] <= d;
            if ($countones(duty[i]) > 1) m_inv[i][c] <= 1'b1;
          end
        end
        if (en[i]) begin
          m_ps[i] <= (cnt == 0) && (m_e[i] % p == 0);
          for (int c = 0; c < CH; c++) begin
            m_pwm[i][c] <= (cnt < m_act[i][c]);
            if (m_e[i] % (p * WL) == p * WL - 1)
              m_act[i][c] <= load[i][c] ? d : m_sh[i][c];
          end
          m_e[i] <= m_e[i] + 1;
        end else begin
          m_ps[i] <= 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; en[i] = 1'b0; load[i] = '0; duty[i] = '0;
    end
    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (pwm[i] !== 4'b0) begin failures++; $display("FAIL reset_pwm[%0d] got=%b exp=0000", i, pwm[i]); end
      checks++;
      if (ps[i] !== 1'b0) begin failures++; $display("FAIL reset_ps[%0d] got=%b exp=0", i, ps[i]); end
      checks++;
      if (inv[i] !== 4'b0) begin failures++; $display("FAIL reset_inv[%0d] got=%b exp=0000", i, inv[i]); end
    end
  endtask

  task automatic test_half_duty();
    logic [7:0] pat;
    int n;
    rst[0] = 1'b0; en[0] = 1'b1;
    load[0] = 4'b0001; duty[0] = 8'b00001000;
    tick();
    load[0] = '0;
    tick();
    n = 0;
    while (ps[0] !== 1'b1 && n < 40) begin tick(); n++; end
    checks++;
    if (ps[0] !== 1'b1) begin failures++; $display("FAIL half_sync got ps=%b exp=1", ps[0]); end
    for (int k = 0; k < 8; k++) begin
      pat[k] = pwm[0][0];
      checks++;
      if (pwm[0] !== m_pwm[0] || ps[0] !== m_ps[0]) begin
        failures++; $display("FAIL half_model pwm=%b exp=%b ps=%b exp=%b", pwm[0], m_pwm[0], ps[0], m_ps[0]);
      end
      tick();
    end
    checks++;
    if (pat !== 8'b00001111) begin failures++; $display("FAIL half_pattern got=%b exp=00001111", pat); end
  endtask

  task automatic test_extremes();
    int n;
    load[0] = 4'b0010; duty[0] = 8'b10000000; tick();
    load[0] = 4'b0100; duty[0] = 8'b00000000; tick();
    load[0] = '0;
    tick();
    n = 0;
    while (ps[0] !== 1'b1 && n < 40) begin tick(); n++; end
    checks++;
    if (ps[0] !== 1'b1) begin failures++; $display("FAIL extreme_sync got ps=%b exp=1", ps[0]); end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (pwm[0][1] !== 1'b1) begin failures++; $display("FAIL extreme_full k=%0d got=%b exp=1", k, pwm[0][1]); end
      checks++;
      if (pwm[0][2] !== 1'b0) begin failures++; $display("FAIL extreme_zero k=%0d got=%b exp=0", k, pwm[0][2]); end
      checks++;
      if (ps[0] !== m_ps[0]) begin failures++; $display("FAIL extreme_ps k=%0d got=%b exp=%b", k, ps[0], m_ps[0]); end
      tick();
    end
  endtask

  task automatic test_mid_change();
    int n;
    int hi1;
    int hi2;
    load[0] = 4'b1000; duty[0] = 8'b00000010; tick();
    load[0] = '0;
    tick();
    n = 0;
    while (ps[0] !== 1'b1 && n < 40) begin tick(); n++; end
    checks++;
    if (ps[0] !== 1'b1) begin failures++; $display("FAIL mid_sync got ps=%b exp=1", ps[0]); end
    hi1 = 0; hi2 = 0;
    for (int k = 0; k < 16; k++) begin
      if (k < 8) hi1 += int'(pwm[0][3]); else hi2 += int'(pwm[0][3]);
      checks++;
      if (pwm[0] !== m_pwm[0]) begin failures++; $display("FAIL mid_model k=%0d got=%b exp=%b", k, pwm[0], m_pwm[0]); end
      if (k == 3) begin load[0] = 4'b1000; duty[0] = 8'b00100000; end
      tick();
      load[0] = '0;
    end
    checks++;
    if (hi1 != 2) begin failures++; $display("FAIL mid_current_high got=%0d exp=2", hi1); end
    checks++;
    if (hi2 != 6) begin failures++; $display("FAIL mid_next_high got=%0d exp=6", hi2); end
  endtask

  task automatic test_wrap_load();
    int n;
    logic [7:0] pat;
    n = 0;
    while ((m_e[0] % 8) != 7 && n < 20) begin tick(); n++; end
    load[0] = 4'b0001; duty[0] = 8'b00000100;
    tick();
    load[0] = '0;
    checks++;
    if (ps[0] !== 1'b0) begin failures++; $display("FAIL wrap_ps_before got=%b exp=0", ps[0]); end
    tick();
    checks++;
    if (ps[0] !== 1'b1) begin failures++; $display("FAIL wrap_ps_after got=%b exp=1", ps[0]); end
    for (int k = 0; k < 8; k++) begin
      pat[k] = pwm[0][0];
      checks++;
      if (pwm[0] !== m_pwm[0]) begin failures++; $display("FAIL wrap_model k=%0d got=%b exp=%b", k, pwm[0], m_pwm[0]); end
      tick();
    end
    checks++;
    if (pat !== 8'b00000111) begin failures++; $display("FAIL wrap_pattern got=%b exp=00000111", pat); end
  endtask

  task automatic test_invalid();
    int n;
    load[0] = 4'b0100; duty[0] = 8'b00010010;
    tick();
    load[0] = '0;
    checks++;
    if (inv[0] !== 4'b0100) begin failures++; $display("FAIL invalid_set got=%b exp=0100", inv[0]); end
    for (int k = 0; k < 20; k++) begin
      load[0] = 4'($urandom) & 4'b1011;
      duty[0] = ($urandom_range(0, 8) == 0) ? 8'b0 : 8'(1 << $urandom_range(0, 7));
      tick();
      checks++;
      if (inv[0] !== 4'b0100) begin failures++; $display("FAIL invalid_sticky k=%0d got=%b exp=0100", k, inv[0]); end
      checks++;
      if (pwm[0] !== m_pwm[0]) begin failures++; $display("FAIL invalid_model k=%0d got=%b exp=%b", k, pwm[0], m_pwm[0]); end
    end
    load[0] = '0;
    tick();
    n = 0;
    while (ps[0] !== 1'b1 && n < 40) begin tick(); n++; end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (pwm[0][2] !== 1'b0) begin failures++; $display("FAIL invalid_low k=%0d got=%b exp=0", k, pwm[0][2]); end
      tick();
    end
  endtask

  task automatic test_prescale();
    int n;
    int len;
    int hi;
    logic [CH-1:0] v;
    rst[1] = 1'b1; en[1] = 1'b1;
    tick(); tick();
    rst[1] = 1'b0;
    load[1] = 4'b0001; duty[1] = 8'b00001000; tick();
    load[1] = '0;
    tick();
    n = 0;
    while (ps[1] !== 1'b1 && n < 60) begin tick(); n++; end
    checks++;
    if (ps[1] !== 1'b1) begin failures++; $display("FAIL pre_sync got ps=%b exp=1", ps[1]); end
    len = 0; hi = 0;
    do begin
      hi += int'(pwm[1][0]);
      tick(); len++;
      checks++;
      if (pwm[1] !== m_pwm[1] || ps[1] !== m_ps[1]) begin
        failures++; $display("FAIL pre_model pwm=%b exp=%b ps=%b exp=%b", pwm[1], m_pwm[1], ps[1], m_ps[1]);
      end
    end while (ps[1] !== 1'b1 && len < 60);
    checks++;
    if (len != 24) begin failures++; $display("FAIL pre_period got=%0d exp=24", len); end
    checks++;
    if (hi != 12) begin failures++; $display("FAIL pre_high got=%0d exp=12", hi); end
    len = 0; v = pwm[1];
    do begin
      if (len == 5) begin v = pwm[1]; en[1] = 1'b0; end
      if (len == 11) en[1] = 1'b1;
      tick(); len++;
      checks++;
      if (pwm[1] !== m_pwm[1] || ps[1] !== m_ps[1]) begin
        failures++; $display("FAIL pre_hold_model pwm=%b exp=%b ps=%b exp=%b", pwm[1], m_pwm[1], ps[1], m_ps[1]);
      end
      if (len >= 6 && len <= 11) begin
        checks++;
        if (pwm[1] !== v) begin failures++; $display("FAIL pre_frozen len=%0d got=%b exp=%b", len, pwm[1], v); end
      end
    end while (ps[1] !== 1'b1 && len < 80);
    checks++;
    if (len != 30) begin failures++; $display("FAIL pre_period_paused got=%0d exp=30", len); end
    repeat (7) tick();
    rst[1] = 1'b1; load[1] = 4'b0001; duty[1] = 8'b10000000;
    tick();
    rst[1] = 1'b0; load[1] = '0;
    checks++;
    if (pwm[1] !== 4'b0 || ps[1] !== 1'b0 || inv[1] !== 4'b0) begin
      failures++; $display("FAIL pre_reset pwm=%b ps=%b inv=%b exp=all zero", pwm[1], ps[1], inv[1]);
    end
    tick();
    checks++;
    if (ps[1] !== 1'b1) begin failures++; $display("FAIL pre_restart_ps got=%b exp=1", ps[1]); end
    for (int k = 0; k < 24; k++) begin
      checks++;
      if (pwm[1] !== 4'b0) begin failures++; $display("FAIL pre_after_reset k=%0d got=%b exp=0000", k, pwm[1]); end
      tick();
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 2; i++) begin
        rst[i]  = ($urandom_range(0, 99) == 0);
        en[i]   = ($urandom_range(0, 99) < 85);
        load[i] = ($urandom_range(0, 99) < 30) ? 4'($urandom) : 4'b0;
        if ($urandom_range(0, 9) == 0) duty[i] = 8'($urandom);
        else if ($urandom_range(0, 8) == 0) duty[i] = 8'b0;
        else duty[i] = 8'(1 << $urandom_range(0, 7));
      end
      tick();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (pwm[i] !== m_pwm[i]) begin failures++; $display("FAIL rand_pwm[%0d] n=%0d got=%b exp=%b", i, n, pwm[i], m_pwm[i]); end
        checks++;
        if (ps[i] !== m_ps[i]) begin failures++; $display("FAIL rand_ps[%0d] n=%0d got=%b exp=%b", i, n, ps[i], m_ps[i]); end
        checks++;
        if (inv[i] !== m_inv[i]) begin failures++; $display("FAIL rand_inv[%0d] n=%0d got=%b exp=%b", i, n, inv[i], m_inv[i]); end
      end
    end
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b0; en[i] = 1'b0; load[i] = '0; duty[i] = '0;
    end
  endtask

  initial begin
    test_reset();
    test_half_duty();
    test_extremes();
    test_mid_change();
    test_wrap_load();
    test_invalid();
    test_prescale();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired before the bench completed");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pwm_multichannel.md
PWM_MULTICHANNEL -- requirements
Module: pwm_multichannel

Interface
REQ-001 SHALL have parameter WORD_LENGTH, default 8: one-hot duty word width; PWM period is WORD_LENGTH steps.
REQ-002 SHALL have parameter CHANNELS, default 4: number of independent PWM outputs.
REQ-003 SHALL have parameter PRESCALE, default 1: clocks per step, legal range >=1.
REQ-004 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port load_i, input, CHANNELS: per-channel duty write strobe.
REQ-007 SHALL have port duty_i, input, WORD_LENGTH: one-hot duty word, shared by all channels.
REQ-008 SHALL have port enable_i, input, 1: step counter runs while high.
REQ-009 SHALL have port pwm_o, output, CHANNELS: registered PWM waveforms.
REQ-010 SHALL have port period_start_o, output, 1: one-clock pulse on the first clock of each period.
REQ-011 SHALL have port invalid_o, output, CHANNELS: sticky flag per channel, set when a non-one-hot nonzero word is loaded.

Function
REQ-012 SHALL decode duty_i to count D in 0..WORD_LENGTH: bit k set alone gives D=k+1; all-zero gives D=0; any other pattern gives D=0.
REQ-013 SHALL write the decoded D into that channel's shadow register on a clock where load_i[c]=1; several channels may load in the same clock.
REQ-014 SHALL set invalid_o[c] on a load of a pattern with two or more bits set; it clears only on reset.
REQ-015 SHALL advance the prescaler while enable_i=1; a tick occurs when the prescaler equals PRESCALE-1, and the prescaler then wraps to 0.
REQ-016 SHALL increment the step counter cnt (0..WORD_LENGTH-1) on each tick and wrap from WORD_LENGTH-1 to 0.
REQ-017 SHALL copy all shadow registers to the active duty registers on the wrap tick (period boundary), never mid-period.
REQ-018 SHALL, when load_i[c] and the wrap tick coincide, place the new D directly in active[c], bypassing the shadow.
REQ-019 SHALL register pwm_o[c] as (cnt < active[c]), one clock after cnt; D=0 gives constant low and D=WORD_LENGTH gives constant high.
REQ-020 SHALL pulse period_start_o in the same clock in which pwm_o first reflects cnt=0.
REQ-021 SHALL freeze the prescaler, cnt and pwm_o while enable_i=0; loads still update the shadow registers.

Reset
REQ-022 SHALL clear prescaler, cnt, shadow, active, pwm_o, period_start_o and invalid_o to 0 on a clock with reset=1.
REQ-023 SHALL give reset priority over load_i and enable_i, including mid-period; the next period starts at cnt=0 with D=0.

Structure
REQ-024 SHALL place the duty count width constant, $clog2(WORD_LENGTH+1), and the channel duty typedef in a shared package pwm_pkg.
REQ-025 SHALL use one combinational sub-module onehot_duty_decoder (duty_i to D plus a multi-hot flag), instantiated once and shared by all channels.
REQ-026 SHALL keep the prescaler and step counter common to all channels, so all channels are phase-aligned.

Verification
REQ-027 SHALL cover: WORD_LENGTH=8, PRESCALE=1, load ch0 with 8'b00001000 -> after the next boundary, ch0 is high 4 clocks and low 4 clocks per 8-clock period.
REQ-028 SHALL cover: load 8'b10000000 -> pwm_o constant high; load 8'b00000000 -> constant low; no glitch at the boundary.
REQ-029 SHALL cover: change duty from 2 to 6 mid-period -> the current period keeps 2 high clocks and the next period has 6.
REQ-030 SHALL cover: load in the wrap-tick clock -> the new duty applies in the immediately following period.
REQ-031 SHALL cover: load 8'b00010010 on ch2 -> invalid_o[2]=1 stays high, D=0; other channels unaffected.
REQ-032 SHALL cover: PRESCALE=3 with reset asserted mid-period and enable_i toggled -> period is 24 clocks; after reset all outputs are 0; counting holds while disabled.
